// File: rtl/seq_divider_pkg.sv
// Shared MDU constants and divider FSM encodings.
package seq_divider_pkg;

  localparam logic [2:0] MDU_OP_MUL   = 3'd0;
  localparam logic [2:0] MDU_OP_MULH  = 3'd1;
  localparam logic [2:0] MDU_OP_MULHU = 3'd2;
  localparam logic [2:0] MDU_OP_DIV   = 3'd4;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd5;
  localparam logic [2:0] MDU_OP_REM   = 3'd6;
  localparam logic [2:0] MDU_OP_REMU  = 3'd7;

  localparam int unsigned DIV_ITERATIONS = 32;
  localparam int unsigned DIV_CNT_W      = 5;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_e;

  function automatic logic div_is_busy(input div_state_e st);
    return (st == DIV_ST_CALC) || (st == DIV_ST_FIX);
  endfunction

endpackage

// File: rtl/seq_divider_abs.sv
// Conditional two's-complement magnitude: negates only when signed and negative.
module seq_divider_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             neg_o
);

  always_comb begin
    neg_o = signed_i & value_i[WIDTH-1];
    mag_o = neg_o ? (~value_i + WIDTH'(1)) : value_i;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned), MDU divide responder.
// Optional SEQ_DIVIDER_FAST_PATH_EN: zero divisor or |dividend| < |divisor| finish on the accept edge.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             signed_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             ready_o,
  output logic             busy_o
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     raw_q, raw_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted, trial;

  seq_divider_abs #(.WIDTH(WIDTH)) u_abs_dividend (
    .value_i  (dividend_i),
    .signed_i (signed_i),
    .mag_o    (a_mag),
    .neg_o    (a_neg)
  );

  seq_divider_abs #(.WIDTH(WIDTH)) u_abs_divisor (
    .value_i  (divisor_i),
    .signed_i (signed_i),
    .mag_o    (b_mag),
    .neg_o    (b_neg)
  );

  // The partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    raw_d       = raw_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      DIV_ST_IDLE, DIV_ST_DONE: begin
        if (start_i) begin
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          raw_d   = dividend_i;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (divisor_i == '0);
          cnt_d   = '0;
          state_d = DIV_ST_CALC;
`ifdef SEQ_DIVIDER_FAST_PATH_EN
          if ((divisor_i == '0) || (a_mag < b_mag)) begin
            quotient_d  = (divisor_i == '0) ? '1 : '0;
            remainder_d = dividend_i;
            state_d     = DIV_ST_DONE;
          end
`endif
        end else begin
          state_d = DIV_ST_IDLE;
        end
      end
      DIV_ST_CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(DIV_ITERATIONS - 1)) begin
          state_d = DIV_ST_FIX;
        end
      end
      DIV_ST_FIX: begin
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = raw_q;
        end else begin
          quotient_d  = qneg_q ? (~quo_q + WIDTH'(1)) : quo_q;
          remainder_d = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
        end
        state_d = DIV_ST_DONE;
      end
      default: state_d = DIV_ST_IDLE;
    endcase

    busy_d  = div_is_busy(state_d);
    ready_d = (state_d == DIV_ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= DIV_ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      raw_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      raw_q       <= raw_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider; expectations follow SEQ_DIVIDER_FAST_PATH_EN when defined.
module tb_seq_divider;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        signed_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] quotient_o, remainder_o;
  logic        ready_o, busy_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

`ifdef SEQ_DIVIDER_FAST_PATH_EN
  localparam int SHORT_LAT  = 1;
  localparam int SHORT_BUSY = 0;
`else
  localparam int SHORT_LAT  = 34;
  localparam int SHORT_BUSY = 33;
`endif

  seq_divider #(.WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .signed_i    (signed_i),
    .start_i     (start_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // lat counts edges from the accept edge (inclusive) to the edge after which ready_o is seen; 0 = timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output int busy_cnt);
    dividend_i = a; divisor_i = b; signed_i = s; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = 0;
    busy_cnt = busy_o ? 1 : 0;
    if (ready_o) lat = 1;
    else begin
      for (int k = 1; k <= 60; k++) begin
        @(posedge clk_i); #1;
        if (busy_o) busy_cnt++;
        if (ready_o) begin lat = k + 1; break; end
      end
    end
    q = quotient_o;
    r = remainder_o;
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b1;
    #1;
    vectors++; if (quotient_o !== 32'h0) begin miscompares++; $display("FAIL reset_q: got %h want 0", quotient_o); end
    vectors++; if (remainder_o !== 32'h0) begin miscompares++; $display("FAIL reset_r: got %h want 0", remainder_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; int lat, bc;
    run_op(32'd100, 32'd7, 1'b0, q, r, lat, bc);
    vectors++; if (q !== 32'd14) begin miscompares++; $display("FAIL u100_7_q: got %0d want 14", q); end
    vectors++; if (r !== 32'd2) begin miscompares++; $display("FAIL u100_7_r: got %0d want 2", r); end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL u100_7_lat: got %0d want 34", lat); end
    vectors++; if (bc !== 33) begin miscompares++; $display("FAIL u100_7_busy: got %0d want 33", bc); end
    @(posedge clk_i); #1;
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL ready_pulse: got %b want 0", ready_o); end
    repeat (3) @(posedge clk_i); #1;
    vectors++; if (quotient_o !== 32'd14 || remainder_o !== 32'd2 || busy_o !== 1'b0)
      begin miscompares++; $display("FAIL hold_idle: got q=%0d r=%0d busy=%b want 14 2 0", quotient_o, remainder_o, busy_o); end

    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, q, r, lat, bc);
    vectors++; if (q !== 32'h7FFF_FFFC) begin miscompares++; $display("FAIL ubig_q: got %h want 7ffffffc", q); end
    vectors++; if (r !== 32'd1) begin miscompares++; $display("FAIL ubig_r: got %h want 1", r); end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; int lat, bc;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat, bc);
    vectors++; if (q !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL sm7_2_q: got %h want fffffffd", q); end
    vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sm7_2_r: got %h want ffffffff", r); end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, lat, bc);
    vectors++; if (q !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL s7_m2_q: got %h want fffffffd", q); end
    vectors++; if (r !== 32'd1) begin miscompares++; $display("FAIL s7_m2_r: got %h want 1", r); end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL s7_m2_lat: got %0d want 34", lat); end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; int lat, bc;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat, bc);
    vectors++; if (q !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_q: got %h want 80000000", q); end
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL ovf_r: got %h want 0", r); end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL ovf_lat: got %0d want 34", lat); end
    // Unsigned 0x80000000 is a plain magnitude, not negated.
    run_op(32'h8000_0000, 32'd3, 1'b0, q, r, lat, bc);
    vectors++; if (q !== 32'h2AAA_AAAA || r !== 32'd2)
      begin miscompares++; $display("FAIL u8000_3: got q=%h r=%h want 2aaaaaaa 2", q, r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; int lat, bc;
    run_op(32'h1234_5678, 32'h0, 1'b0, q, r, lat, bc);
    vectors++; if (q !== 32'hFFFF_FFFF || r !== 32'h1234_5678)
      begin miscompares++; $display("FAIL dz_u: got q=%h r=%h want ffffffff 12345678", q, r); end
    vectors++; if (lat !== SHORT_LAT || bc !== SHORT_BUSY)
      begin miscompares++; $display("FAIL dz_u_lat: got lat=%0d busy=%0d want %0d %0d", lat, bc, SHORT_LAT, SHORT_BUSY); end
    run_op(32'h1234_5678, 32'h0, 1'b1, q, r, lat, bc);
    vectors++; if (q !== 32'hFFFF_FFFF || r !== 32'h1234_5678)
      begin miscompares++; $display("FAIL dz_s: got q=%h r=%h want ffffffff 12345678", q, r); end
    run_op(32'hFFFF_FFF0, 32'h0, 1'b1, q, r, lat, bc);
    vectors++; if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF0)
      begin miscompares++; $display("FAIL dz_sneg: got q=%h r=%h want ffffffff fffffff0", q, r); end
    vectors++; if (lat !== SHORT_LAT) begin miscompares++; $display("FAIL dz_sneg_lat: got %0d want %0d", lat, SHORT_LAT); end
  endtask

  task automatic test_small_dividend();
    logic [31:0] q, r; int lat, bc;
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, q, r, lat, bc);
    vectors++; if (q !== 32'h0 || r !== 32'hFFFF_FFFD)
      begin miscompares++; $display("FAIL sm3_5: got q=%h r=%h want 0 fffffffd", q, r); end
    vectors++; if (lat !== SHORT_LAT || bc !== SHORT_BUSY)
      begin miscompares++; $display("FAIL sm3_5_lat: got lat=%0d busy=%0d want %0d %0d", lat, bc, SHORT_LAT, SHORT_BUSY); end
  endtask

  task automatic test_start_ignored();
    int lat;
    dividend_i = 32'd1000; divisor_i = 32'd10; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin dividend_i = 32'd5; divisor_i = 32'd1; start_i = 1'b1; end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (ready_o) begin lat = k + 1; break; end
    end
    vectors++; if (quotient_o !== 32'd100 || remainder_o !== 32'd0)
      begin miscompares++; $display("FAIL start_in_calc: got q=%0d r=%0d want 100 0", quotient_o, remainder_o); end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL start_in_calc_lat: got %0d want 34", lat); end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] q, r; int lat, bc;
    dividend_i = 32'd50; divisor_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy_o); end
    #2 rst_i = 1'b1;
    #1;
    vectors++; if (busy_o !== 1'b0 || ready_o !== 1'b0)
      begin miscompares++; $display("FAIL rst_async_ctl: got busy=%b ready=%b want 0 0", busy_o, ready_o); end
    vectors++; if (quotient_o !== 32'h0 || remainder_o !== 32'h0)
      begin miscompares++; $display("FAIL rst_async_data: got q=%h r=%h want 0 0", quotient_o, remainder_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    run_op(32'd100, 32'd7, 1'b0, q, r, lat, bc);
    vectors++; if (q !== 32'd14 || r !== 32'd2 || lat !== 34)
      begin miscompares++; $display("FAIL after_rst: got q=%0d r=%0d lat=%0d want 14 2 34", q, r, lat); end
  endtask

  task automatic test_back_to_back();
    int gap;
    bit seen;
    dividend_i = 32'd20; divisor_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    seen = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk_i); #1;
      if (ready_o) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen || quotient_o !== 32'd6 || remainder_o !== 32'd2)
      begin miscompares++; $display("FAIL b2b_first: got seen=%0d q=%0d r=%0d want 1 6 2", seen, quotient_o, remainder_o); end
    dividend_i = 32'd9; divisor_i = 32'd9;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy=%b want 1", busy_o); end
    gap = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk_i); #1;
      if (ready_o) begin gap = k + 1; break; end
    end
    vectors++; if (quotient_o !== 32'd1 || remainder_o !== 32'd0)
      begin miscompares++; $display("FAIL b2b_second: got q=%0d r=%0d want 1 0", quotient_o, remainder_o); end
    vectors++; if (gap !== 34) begin miscompares++; $display("FAIL b2b_gap: got %0d want 34", gap); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_small_dividend();
    test_start_ignored();
    test_reset_mid_calc();
    test_back_to_back();
    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle 32-bit radix-2 restoring divider, signed and unsigned. It is the responder on the MDU's divide handshake. The MDU pulses `start_i` with operands and a sign flag, watches `busy_o`, and latches `quotient_o`/`remainder_o` when `ready_o` pulses. The divider sits inside the MDU, beside the combinational multiplier, and owns no HI/LO state.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is verified.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `dividend_i`  in  WIDTH  dividend; sampled only on the accept edge.
- `divisor_i`  in  WIDTH  divisor; sampled only on the accept edge.
- `signed_i`  in  1  1 = two's-complement operation, 0 = unsigned; sampled on the accept edge.
- `start_i`  in  1  request; accepted at a rising edge while the state is IDLE or DONE.
- `quotient_o`  out  WIDTH  registered quotient; reset 0.
- `remainder_o`  out  WIDTH  registered remainder; reset 0.
- `ready_o`  out  1  one-cycle pulse; results valid; reset 0.
- `busy_o`  out  1  high while computing; reset 0.

## Operation
- States and transitions:
  - IDLE → CALC on `start_i`.
  - CALC → FIX after 32 iterations.
  - FIX → DONE.
  - DONE → CALC on `start_i`, otherwise DONE → IDLE.
- Accept edge:
  - Latch |dividend| and |divisor| as WIDTH-bit magnitudes. Absolute values are taken only when `signed_i` = 1; 0x80000000 stays 0x80000000 as an unsigned magnitude.
  - Latch quotient-negate = signs differ, remainder-negate = dividend negative, divisor-zero flag, and the raw dividend.
  - Clear the iteration counter.
- CALC, each cycle:
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude in WIDTH+1 bits.
  - If the result is non-negative, keep it and set quotient LSB = 1.
  - Increment the counter; leave CALC after 32 iterations.
- FIX:
  - Apply the negations.
  - Write `quotient_o`/`remainder_o`.
  - Division is truncating: the remainder takes the dividend's sign, and |remainder| < |divisor|.
- Divide by zero, signed or unsigned: result is quotient 0xFFFFFFFF, remainder = raw dividend. Sign fix is bypassed. Latency is normal.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of the datapath with no special case.
- `start_i` in CALC/FIX is ignored; operands and outputs are unaffected.
- `quotient_o`/`remainder_o` hold their value until the next FIX, including through IDLE.

## Timing
- `start_i` sampled at edge T:
  - `busy_o` = 1 in the cycles after edges T … T+32, i.e. 33 cycles (CALC ×32, FIX ×1).
  - `ready_o` = 1 only in the cycle after edge T+33 (DONE), with `busy_o` = 0 and results valid.
- `busy_o` and `ready_o` are decoded from the state register only: no combinational path from any input.
- If `start_i` is high in DONE, edge T+34 accepts a new operation. Back-to-back throughput is one result per 34 cycles.
- Reset asserted at any time, including mid-CALC: the state is IDLE immediately, and all outputs and the counter are 0 without waiting for a clock edge.

## Configuration
- Macro: `SEQ_DIVIDER_FAST_PATH_EN`.
- Defined, signed/unsigned per `signed_i`:
  - If the divisor is zero, or |dividend| < |divisor|, the accept edge writes the result directly and goes straight to DONE.
  - Result for |dividend| < |divisor|: quotient 0, remainder = raw dividend.
  - Result for zero divisor: the divide-by-zero rule above.
  - `busy_o` never rises for these operations; `ready_o` pulses in the cycle after edge T.
- Not defined: every operation takes the full 34-cycle path. Results are identical either way; only latency differs.

## Structure
- Shared constants include, beside the MDU opcodes:
  - state encodings `DIV_ST_IDLE`, `DIV_ST_CALC`, `DIV_ST_FIX`, `DIV_ST_DONE` (2 bits);
  - `DIV_ITERATIONS` = 32;
  - `DIV_CNT_W` = 5.
- One sub-module, `seq_divider_abs`: combinational conditional magnitude (input, sign enable) → (magnitude, sign bit). Instantiated twice, for dividend and divisor.
- Counter, FSM and datapath live in `seq_divider`.

## Test plan
- Unsigned 100 / 7, `signed_i` = 0 → quotient 14, remainder 2. `busy_o` high exactly 33 cycles; `ready_o` one pulse 34 edges after the accept edge.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 1. Unsigned 0xFFFFFFF9 / 2 → quotient 0x7FFFFFFC, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, no hang.
- 0x12345678 / 0, both sign modes → quotient 0xFFFFFFFF, remainder 0x12345678. Latency is 34 edges, or 1 edge with `SEQ_DIVIDER_FAST_PATH_EN`.
- Start 1000 / 10. Re-pulse `start_i` with 5 / 1 during CALC → result stays quotient 100, remainder 0. Later, assert `rst_i` mid-CALC → `busy_o`, `ready_o` and outputs go to 0 asynchronously; the next start completes normally.
- `start_i` held high across two operations (20 / 3, then 9 / 9) → second accepted in the DONE cycle. Results 6 r 2 then 1 r 0, `ready_o` pulses 34 cycles apart.
